// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; HALT_OPCODE is also used by decode.
package fetch_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam logic [DEF_DATA_W-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset to RESET_PC, then load, increment or hold.
module pc_reg #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load)
            pc_d = load_val;
        else if (inc)
            pc_d = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives memory address from the PC, registers the instruction and
// hands it to decode over valid/ready, with branch squash and halt detection.
module instruction_fetch #(
    parameter int                ADDR_W      = fetch_pkg::DEF_ADDR_W,
    parameter int                DATA_W      = fetch_pkg::DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [DATA_W-1:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] instruction_address,
    input  logic [DATA_W-1:0] instruction_data,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              decode_ready,
    output logic [DATA_W-1:0] fetched_instruction,
    output logic [ADDR_W-1:0] fetched_pc,
    output logic              fetch_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);
    import fetch_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_load, pc_inc, transfer;

    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (branch_target),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign transfer = valid_q && decode_ready;

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        fpc_d    = fpc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        // A transfer counts even if a branch squashes the next register contents.
        count_d  = (transfer && count_q != '1) ? count_q + CNT_W'(1) : count_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                end else if (!(valid_q && !decode_ready)) begin
                    instr_d = instruction_data;
                    fpc_d   = pc;
                    valid_d = 1'b1;
                    if (instruction_data == HALT_OPCODE) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
            end
            HALT: if (transfer) valid_d = 1'b0;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            fpc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            fpc_q    <= fpc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign instruction_address = pc;
    assign fetched_instruction = instr_q;
    assign fetched_pc          = fpc_q;
    assign fetch_valid         = valid_q;
    assign halted              = halted_q;
    assign fetch_count         = count_q;

endmodule
